// File: rtl/core_pkg.sv
// Shared encodings for the Selen core: write-back result sources, load types
// and the write-back FSM state.
package core_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_LD  = 2'd1;
    localparam logic [1:0] WB_SRC_IMM = 2'd2;
    localparam logic [1:0] WB_SRC_PC4 = 2'd3;

    localparam logic [2:0] SX_LB  = 3'b000;
    localparam logic [2:0] SX_LH  = 3'b001;
    localparam logic [2:0] SX_LW  = 3'b010;
    localparam logic [2:0] SX_LBU = 3'b100;
    localparam logic [2:0] SX_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_ACK = 1'b1
    } wb_state_t;

endpackage

// File: rtl/core_wb_ld_ext.sv
// Load-data extractor: picks the addressed byte/half of the response word and
// sign- or zero-extends it. Unknown load types pass the whole word through.
module core_wb_ld_ext
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  sx_type,
    output logic [31:0] data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[off];
    // Halfword selection deliberately ignores off[0]; misaligned halves are not split.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (sx_type)
            SX_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            SX_LBU:  data = {24'd0, byte_sel};
            SX_LH:   data = {{16{half_sel[15]}}, half_sel};
            SX_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/core_wb_s.sv
// Write-back stage: result selection, load-response wait with upstream stall,
// registered register-file write port. Optional load timeout: CORE_WB_TIMEOUT_EN.
module core_wb_s
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_val_in,
    input  logic        wb_kill_in,
    input  logic        wb_we_reg_file_in,
    input  logic        wb_ld_in,
    input  logic [1:0]  wb_src_in,
    input  logic [2:0]  wb_sx_type_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_alu_result_in,
    input  logic [31:0] wb_sx_imm_in,
    input  logic [31:0] wb_pc_4_in,
    input  logic        l1d2wb_ack_in,
    input  logic [31:0] l1d2wb_rdata_in,
    output logic        wb2rf_we_out,
    output logic [4:0]  wb2rf_rd_out,
    output logic [31:0] wb2rf_data_out,
    output logic [31:0] wb2exe_bp_data_out,
    output logic        wb_stall_out,
    output logic        wb_err_out
);

    wb_state_t   state_reg, state_next;

    logic        acc;
    logic        timeout_hit;

    logic [4:0]  pend_rd_reg;
    logic        pend_we_reg;
    logic [2:0]  pend_sx_reg;
    logic [1:0]  pend_off_reg;

    logic        we_reg, we_next;
    logic [4:0]  rd_reg, rd_next;
    logic [31:0] data_reg, data_next;
    logic        err_reg, err_next;
    logic        stall;

    logic [1:0]  ext_off;
    logic [2:0]  ext_sx;
    logic [31:0] ld_data;
    logic [31:0] src_result;

    assign acc = wb_val_in & ~wb_kill_in;

    // While waiting, extraction uses the latched load attributes, not the (held) inputs.
    assign ext_off = (state_reg == WB_WAIT_ACK) ? pend_off_reg : wb_alu_result_in[1:0];
    assign ext_sx  = (state_reg == WB_WAIT_ACK) ? pend_sx_reg  : wb_sx_type_in;

    core_wb_ld_ext u_ld_ext (
        .rdata   (l1d2wb_rdata_in),
        .off     (ext_off),
        .sx_type (ext_sx),
        .data    (ld_data)
    );

    always_comb begin
        src_result = wb_alu_result_in;
        case (wb_src_in)
            WB_SRC_ALU: src_result = wb_alu_result_in;
            WB_SRC_LD:  src_result = ld_data;
            WB_SRC_IMM: src_result = wb_sx_imm_in;
            WB_SRC_PC4: src_result = wb_pc_4_in;
            default:    src_result = wb_alu_result_in;
        endcase
    end

`ifdef CORE_WB_TIMEOUT_EN
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    logic [7:0] cnt_reg;

    // Fires on the TIMEOUT_CYCLES-th consecutive ack-less WAIT_ACK cycle.
    assign timeout_hit = (state_reg == WB_WAIT_ACK) && !l1d2wb_ack_in &&
                         (({1'b0, cnt_reg} + 9'd1) == TIMEOUT_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == WB_IDLE) begin
            cnt_reg <= 8'd0;
        end else if (!l1d2wb_ack_in) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_IDLE: begin
                if (acc && wb_ld_in && !l1d2wb_ack_in) begin
                    state_next = WB_WAIT_ACK;
                end
            end
            WB_WAIT_ACK: begin
                if (l1d2wb_ack_in || timeout_hit) begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        we_next   = 1'b0;
        rd_next   = rd_reg;
        data_next = data_reg;
        err_next  = 1'b0;
        stall     = 1'b0;
        case (state_reg)
            WB_IDLE: begin
                if (acc) begin
                    if (!wb_ld_in) begin
                        rd_next   = wb_rd_in;
                        data_next = src_result;
                        we_next   = wb_we_reg_file_in & (wb_rd_in != 5'd0);
                    end else if (l1d2wb_ack_in) begin
                        rd_next   = wb_rd_in;
                        data_next = ld_data;
                        we_next   = wb_we_reg_file_in & (wb_rd_in != 5'd0);
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WB_WAIT_ACK: begin
                stall = 1'b1;
                if (l1d2wb_ack_in) begin
                    rd_next   = pend_rd_reg;
                    data_next = ld_data;
                    we_next   = pend_we_reg & (pend_rd_reg != 5'd0);
                end else if (timeout_hit) begin
                    err_next = 1'b1;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd_reg  <= 5'd0;
            pend_we_reg  <= 1'b0;
            pend_sx_reg  <= SX_LW;
            pend_off_reg <= 2'd0;
        end else if (state_reg == WB_IDLE && acc && wb_ld_in && !l1d2wb_ack_in) begin
            pend_rd_reg  <= wb_rd_in;
            pend_we_reg  <= wb_we_reg_file_in;
            pend_sx_reg  <= wb_sx_type_in;
            pend_off_reg <= wb_alu_result_in[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg   <= 1'b0;
            rd_reg   <= 5'd0;
            data_reg <= 32'd0;
            err_reg  <= 1'b0;
        end else begin
            we_reg   <= we_next;
            rd_reg   <= rd_next;
            data_reg <= data_next;
            err_reg  <= err_next;
        end
    end

    assign wb2rf_we_out       = we_reg;
    assign wb2rf_rd_out       = rd_reg;
    assign wb2rf_data_out     = data_reg;
    assign wb2exe_bp_data_out = data_reg;
    assign wb_stall_out       = stall;
    assign wb_err_out         = err_reg;

endmodule
